// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 channel selector with settle delay, valid/ready output
// and an optional scan mode that walks channels from sel_in up to N_CH-1.
module mux_scan_nto1 #(
    parameter int N_CH   = 16,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   in_bus,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     start,
    input  logic                     abort,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_VALID} state_t;

    localparam logic [SEL_W:0]   NCH_L    = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
    localparam logic [7:0]       SETTLE_L = 8'(SETTLE);

    state_t              state_q;
    logic [SEL_W-1:0]    ch_q;
    logic                mode_q;
    logic [7:0]          cnt_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [SEL_W-1:0]    out_ch_q;
    logic                out_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   cap_data_d;

    logic [DATA_W-1:0]   ch_data [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_data[gi] = in_bus[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        cap_data_d = ch_data[ch_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // abort outranks start even while idle
                    if (start && !abort) begin
                        if ({1'b0, sel_in} < NCH_L) begin
                            ch_q    <= sel_in;
                            mode_q  <= mode;
                            cnt_q   <= SETTLE_L;
                            state_q <= S_SETTLE;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        out_data_q  <= cap_data_d;
                        out_ch_q    <= ch_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!mode_q || ch_q == LAST_CH) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            ch_q    <= ch_q + 1'b1;
                            cnt_q   <= SETTLE_L;
                            state_q <= S_SETTLE;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed/randomised bench for mux_scan_nto1: a 16-channel instance for the
// main flows and a 12-channel instance for out-of-range select handling.
module tb_mux_scan_nto1;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_bus = '0;
    logic        mode = 1'b0;
    logic [3:0]  sel_in = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic [0:0]  out_data;
    logic [3:0]  out_ch;
    logic        out_valid, busy, done, err;

    logic [11:0] b_in_bus = '0;
    logic        b_mode = 1'b0;
    logic [3:0]  b_sel_in = '0;
    logic        b_start = 1'b0;
    logic        b_out_ready = 1'b0;
    logic [0:0]  b_out_data;
    logic [3:0]  b_out_ch;
    logic        b_out_valid, b_busy, b_done, b_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] bus_ref;

    always #5 clk = ~clk;

    mux_scan_nto1 #(.N_CH(16), .DATA_W(1), .SEL_W(4), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .mode(mode), .sel_in(sel_in),
        .start(start), .abort(abort), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .err(err)
    );

    mux_scan_nto1 #(.N_CH(12), .DATA_W(1), .SEL_W(4), .SETTLE(SETTLE)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_bus(b_in_bus), .mode(b_mode), .sel_in(b_sel_in),
        .start(b_start), .abort(1'b0), .out_data(b_out_data), .out_ch(b_out_ch),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy), .done(b_done), .err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) at negedges for out_valid, counting clock edges.
    task automatic wait_valid(input int e0, output int e);
        e = e0;
        while (!out_valid && e < 64) begin
            @(posedge clk);
            @(negedge clk);
            e++;
        end
        chk("valid_seen", {31'd0, out_valid}, 1);
    endtask

    // Reference: a direct op yields one beat on sel; a scan yields beats sel..15.
    // Each beat carries bit ch of the bus value held during settling and
    // appears SETTLE+2 edges after the start/accept edge (counting that edge).
    task automatic do_op(input logic m, input logic [3:0] sel, input logic [15:0] bus,
                         input int stall_min, input int stall_max, input int abort_ch);
        int last, e, stall;
        bus_ref = bus;
        last = m ? 15 : int'(sel);
        @(negedge clk);
        in_bus = bus_ref; mode = m; sel_in = sel; start = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e = 1;
        for (int ch = int'(sel); ch <= last; ch++) begin
            wait_valid(e, e);
            chk("latency", e, SETTLE + 2);
            chk("beat_ch", {28'd0, out_ch}, ch);
            chk("beat_data", {31'd0, out_data}, {31'd0, bus_ref[ch]});
            chk("beat_busy", {31'd0, busy}, 1);
            $display("beat ch=%0d data=%0d mode=%0d", out_ch, out_data, m);
            if (ch == abort_ch) begin
                abort = 1'b1; out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                abort = 1'b0; out_ready = 1'b0;
                chk("abort_valid", {31'd0, out_valid}, 0);
                chk("abort_busy", {31'd0, busy}, 0);
                chk("abort_done", {31'd0, done}, 0);
                @(negedge clk);
                chk("abort_done2", {31'd0, done}, 0);
                return;
            end
            stall = $urandom_range(stall_max, stall_min);
            for (int s = 0; s < stall; s++) begin
                in_bus = 16'($urandom);
                @(posedge clk);
                @(negedge clk);
                chk("hold_valid", {31'd0, out_valid}, 1);
                chk("hold_data", {31'd0, out_data}, {31'd0, bus_ref[ch]});
                chk("hold_ch", {28'd0, out_ch}, ch);
            end
            in_bus = bus_ref;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            e = 1;
            chk("accept_valid", {31'd0, out_valid}, 0);
            chk("accept_err", {31'd0, err}, 0);
            if (ch == last) begin
                chk("done_pulse", {31'd0, done}, 1);
                chk("done_busy", {31'd0, busy}, 0);
                @(negedge clk);
                chk("done_clear", {31'd0, done}, 0);
            end else begin
                chk("mid_done", {31'd0, done}, 0);
                chk("mid_busy", {31'd0, busy}, 1);
            end
        end
    endtask

    initial begin
        int e;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_ch", {28'd0, out_ch}, 0);
        chk("rst_data", {31'd0, out_data}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b0, 4'd5, 16'hA5C3, 0, 0, -1);
        do_op(1'b1, 4'd0, 16'h00FF, 0, 0, -1);
        do_op(1'b0, 4'd3, 16'($urandom), 10, 10, -1);
        do_op(1'b1, 4'd2, 16'($urandom), 0, 0, 6);
        do_op(1'b0, 4'($urandom_range(15, 0)), 16'($urandom), 0, 2, -1);
        for (int r = 0; r < 6; r++)
            do_op(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 16'($urandom), 0, 3, -1);

        // abort together with start while idle: start must be dropped
        @(negedge clk);
        start = 1'b1; abort = 1'b1; sel_in = 4'd1; mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", {31'd0, busy}, 0);
        chk("idle_abort_err", {31'd0, err}, 0);

        // invalid select on the 12-channel instance, then a one-beat scan on ch 11
        @(negedge clk);
        b_in_bus = 12'h800; b_sel_in = 4'd13; b_mode = 1'b0; b_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_start = 1'b0;
        chk("inv_err", {31'd0, b_err}, 1);
        chk("inv_busy", {31'd0, b_busy}, 0);
        @(negedge clk);
        chk("inv_err_clear", {31'd0, b_err}, 0);
        b_sel_in = 4'd11; b_mode = 1'b1; b_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_start = 1'b0;
        e = 1;
        while (!b_out_valid && e < 64) begin
            @(posedge clk);
            @(negedge clk);
            e++;
        end
        chk("b_latency", e, SETTLE + 2);
        chk("b_ch", {28'd0, b_out_ch}, 11);
        chk("b_data", {31'd0, b_out_data}, 1);
        $display("beat12 ch=%0d data=%0d", b_out_ch, b_out_data);
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b_done", {31'd0, b_done}, 1);
        chk("b_busy_end", {31'd0, b_busy}, 0);
        repeat (SETTLE + 3) @(negedge clk);
        chk("b_no_more_beats", {31'd0, b_out_valid}, 0);
        b_out_ready = 1'b0;

        // reset during settle on ch 4 of a scan; a start issued while busy is ignored
        @(negedge clk);
        bus_ref = 16'($urandom);
        in_bus = bus_ref; mode = 1'b1; sel_in = 4'd0; start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mode = 1'b0; sel_in = 4'd9;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            wait_valid(1, e);
            chk("rs_ch", {28'd0, out_ch}, k);
            chk("rs_data", {31'd0, out_data}, {31'd0, bus_ref[k]});
            chk("rs_err", {31'd0, err}, 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("rs_busy_pre", {31'd0, busy}, 1);
        chk("rs_valid_pre", {31'd0, out_valid}, 0);
        rst_n = 1'b0;
        #1;
        chk("rs_busy", {31'd0, busy}, 0);
        chk("rs_valid", {31'd0, out_valid}, 0);
        chk("rs_outch", {28'd0, out_ch}, 0);
        chk("rs_outdata", {31'd0, out_data}, 0);
        chk("rs_done", {31'd0, done}, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0;
        repeat (SETTLE + 3) @(negedge clk);
        chk("rs_idle_busy", {31'd0, busy}, 0);
        chk("rs_idle_valid", {31'd0, out_valid}, 0);
        chk("rs_idle_done", {31'd0, done}, 0);

        do_op(1'b0, 4'd15, 16'($urandom), 0, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
